cdr_gain_ctrl: RTL and testbench
================================

CDR_GAIN_CTRL -- requirements
Module: cdr_gain_ctrl

Interface
REQ-001 Parameter WIN_LEN, default 64: vote-window length in BitCLK cycles, power of two, at least 8.
REQ-002 Parameter LOCK_THR, default 4: maximum |net vote| in a window for the window to count as quiet.
REQ-003 Parameter UNLOCK_THR, default 16: |net vote| above which a tracking state counts as lost.
REQ-004 Parameter ACQ_MAX_WIN, default 32: ACQ windows allowed before timeout (CDR_GAIN_CTRL_TIMEOUT_EN only).
REQ-005 BitCLK  in  1  sole clock, all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  loop enable.
REQ-008 early  in  1  phase-detector early vote for this cycle.
REQ-009 late  in  1  phase-detector late vote for this cycle.
REQ-010 gainsel  out  2  loop-gain select to the CDR: 2 = step 4, 1 = step 2, 0 = step 1.
REQ-011 locked  out  1  high only in state LOCKED.
REQ-012 gain_upd  out  1  one-cycle pulse in the first cycle a new gainsel value is driven.
REQ-013 acq_timeout  out  1  sticky timeout flag (CDR_GAIN_CTRL_TIMEOUT_EN only).

Function
REQ-014 States: IDLE, ACQ, MED, FINE, LOCKED; gainsel is 2, 2, 1, 0, 0 in those states; all outputs registered.
REQ-015 Vote per cycle: early only = -1; late only = +1; both or neither = 0.
REQ-016 Window counter: runs 0..WIN_LEN-1 every cycle in any state other than IDLE; wraps to 0.
REQ-017 Net accumulator: signed, width clog2(WIN_LEN)+2, no saturation; sums votes within the current window.
REQ-018 Window-end cycle: the cycle in which the counter equals WIN_LEN-1; evaluation uses the net including that cycle's vote.
REQ-019 After a window-end cycle, both the counter and the net restart from 0 in the following cycle.
REQ-020 IDLE -> ACQ: on the cycle after en is sampled high.
REQ-021 On a quiet window (|net| <= LOCK_THR): ACQ -> MED, MED -> FINE, FINE -> LOCKED, LOCKED stays LOCKED.
REQ-022 On a lost window (|net| > UNLOCK_THR) in MED, FINE or LOCKED: return to ACQ.
REQ-023 Any other window result leaves the state unchanged.
REQ-024 Transition latency: the new state, gainsel and gain_upd appear exactly 1 cycle after the window-end cycle.
REQ-025 en low in any state: go to IDLE next cycle and clear the counter and net.
REQ-026 en low has priority over any window-end evaluation in the same cycle.
REQ-027 gain_upd: pulses only when gainsel actually changes; FINE -> LOCKED produces no pulse.

Reset
REQ-028 Reset=1: state IDLE, gainsel=2, locked=0, gain_upd=0, counter=0, net=0, acq_timeout=0.
REQ-029 Reset overrides en; reset mid-window discards the partial window.

Configuration
REQ-030 CDR_GAIN_CTRL_TIMEOUT_EN defined: an ACQ window counter increments at each ACQ window end and clears on leaving ACQ.
REQ-031 When that counter reaches ACQ_MAX_WIN: acq_timeout sets and stays set until Reset; the state stays ACQ and the counter restarts.
REQ-032 CDR_GAIN_CTRL_TIMEOUT_EN undefined: no ACQ window counter, no acq_timeout port, no ACQ_MAX_WIN logic.

Structure
REQ-033 Package cdr_ctrl_pkg holds the state enum, the gainsel encoding constants (GAIN_STEP4=2, GAIN_STEP2=1, GAIN_STEP1=0) and the vote type.
REQ-034 Sub-module cdr_vote_window holds the window counter and net accumulator and outputs win_end and the net value; the FSM lives in cdr_gain_ctrl.

Verification (WIN_LEN=16, LOCK_THR=2, UNLOCK_THR=8, ACQ_MAX_WIN=4)
REQ-035 Reset=1 for 3 cycles, then en=1, no votes -> gainsel 2->1 at cycle 17, 1->0 at cycle 33, locked=1 at cycle 49 (counted from ACQ entry); gain_upd pulses twice.
REQ-036 ACQ with early=1 every cycle -> net=-16 each window; stays ACQ with gainsel=2; with the macro, acq_timeout=1 after the 4th window.
REQ-037 LOCKED, then 9 late votes in one window -> ACQ, gainsel=2, locked=0 one cycle after window end, gain_upd=1.
REQ-038 early=late=1 every cycle from ACQ -> treated as no vote; reaches LOCKED at cycle 49.
REQ-039 en dropped at counter=7 in MED -> IDLE next cycle, gainsel=2; en re-raised -> new window starts at 0 and ACQ entry is observed.
REQ-040 Window-end cycle coinciding with en=0 -> IDLE wins and there is no MED/FINE transition.

Source files
------------

// File: rtl/cdr_ctrl_pkg.sv
// Shared types for the CDR loop-gain controller: FSM states, gain-select codes and the vote type.
package cdr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_MED,
    ST_FINE,
    ST_LOCKED
  } state_t;

  localparam logic [1:0] GAIN_STEP4 = 2'd2;
  localparam logic [1:0] GAIN_STEP2 = 2'd1;
  localparam logic [1:0] GAIN_STEP1 = 2'd0;

  typedef logic signed [1:0] vote_t;

  // Early alone pulls the phase back, late alone pushes it forward, both or neither cancel.
  function automatic vote_t vote_of(input logic early, input logic late);
    vote_t v;
    v = 2'sd0;
    if (early && !late) begin
      v = -2'sd1;
    end else if (late && !early) begin
      v = 2'sd1;
    end
    return v;
  endfunction

  function automatic logic [1:0] gain_of(input state_t st);
    logic [1:0] g;
    case (st)
      ST_MED:              g = GAIN_STEP2;
      ST_FINE, ST_LOCKED:  g = GAIN_STEP1;
      default:             g = GAIN_STEP4;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/cdr_vote_window.sv
// Vote window: counts WIN_LEN cycles and accumulates the net phase-detector vote per window.
module cdr_vote_window
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LEN = 64
) (
  input  logic                               BitCLK,
  input  logic                               Reset,
  input  logic                               run,
  input  logic                               early,
  input  logic                               late,
  output logic                               win_end,
  output logic signed [$clog2(WIN_LEN)+1:0]  win_net_c
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN);
  localparam int unsigned NET_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

  logic [CNT_W-1:0]        cnt;
  logic signed [NET_W-1:0] net;
  vote_t                   vote;

  // The evaluated net already includes the vote of the current cycle.
  always_comb begin
    vote      = vote_of(early, late);
    win_net_c = net + NET_W'(vote);
    win_end   = run && (cnt == CNT_LAST);
  end

  always_ff @(posedge BitCLK) begin
    if (Reset || !run || win_end) begin
      cnt <= '0;
      net <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      net <= win_net_c;
    end
  end

endmodule

// File: rtl/cdr_gain_ctrl.sv
// CDR loop-gain controller: steps gain down on quiet vote windows, back to acquisition on lost ones.
// Optional CDR_GAIN_CTRL_TIMEOUT_EN adds a sticky acq_timeout after ACQ_MAX_WIN windows in ACQ.
module cdr_gain_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned LOCK_THR   = 4,
  parameter int unsigned UNLOCK_THR = 16
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned ACQ_MAX_WIN = 32
`endif
) (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic       en,
  input  logic       early,
  input  logic       late,
  output logic [1:0] gainsel,
  output logic       locked,
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
  output logic       gain_upd,
  output logic       acq_timeout
`else
  output logic       gain_upd
`endif
);

  localparam int unsigned NET_W = $clog2(WIN_LEN) + 2;

  state_t                  state;
  state_t                  state_nxt;
  logic                    run;
  logic                    win_end;
  logic signed [NET_W-1:0] win_net_c;
  logic [NET_W-1:0]        net_mag;
  logic                    quiet;
  logic                    lost;
  logic [1:0]              gain_nxt;

  assign run = en && (state != ST_IDLE);

  cdr_vote_window #(
    .WIN_LEN (WIN_LEN)
  ) u_vote_window (
    .BitCLK    (BitCLK),
    .Reset     (Reset),
    .run       (run),
    .early     (early),
    .late      (late),
    .win_end   (win_end),
    .win_net_c (win_net_c)
  );

  // Window classification; |net| never reaches the most negative code, so the negation is safe.
  always_comb begin
    net_mag = win_net_c[NET_W-1] ? $unsigned(-win_net_c) : $unsigned(win_net_c);
    quiet   = win_end && (32'(net_mag) <= LOCK_THR);
    lost    = win_end && (32'(net_mag) > UNLOCK_THR);
  end

  // Next state; dropping en wins over any window result in the same cycle.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (quiet) state_nxt = ST_MED;
        end
        ST_MED: begin
          if (quiet)     state_nxt = ST_FINE;
          else if (lost) state_nxt = ST_ACQ;
        end
        ST_FINE: begin
          if (quiet)     state_nxt = ST_LOCKED;
          else if (lost) state_nxt = ST_ACQ;
        end
        ST_LOCKED: begin
          if (lost) state_nxt = ST_ACQ;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    gain_nxt = gain_of(state_nxt);
  end

  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      gainsel  <= GAIN_STEP4;
      locked   <= 1'b0;
      gain_upd <= 1'b0;
    end else begin
      state    <= state_nxt;
      gainsel  <= gain_nxt;
      locked   <= (state_nxt == ST_LOCKED);
      gain_upd <= (gain_nxt != gainsel);
    end
  end

`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
  localparam int unsigned ACQ_W = $clog2(ACQ_MAX_WIN + 1);

  logic [ACQ_W-1:0] acq_win_cnt;

  // Counts unsuccessful ACQ windows; the flag is sticky until reset, the count restarts.
  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      acq_win_cnt <= '0;
      acq_timeout <= 1'b0;
    end else if (state_nxt != ST_ACQ) begin
      acq_win_cnt <= '0;
    end else if ((state == ST_ACQ) && win_end) begin
      if (32'(acq_win_cnt) == ACQ_MAX_WIN - 1) begin
        acq_win_cnt <= '0;
        acq_timeout <= 1'b1;
      end else begin
        acq_win_cnt <= acq_win_cnt + ACQ_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdr_gain_ctrl.sv
// Directed bench for cdr_gain_ctrl with WIN_LEN=16, LOCK_THR=2, UNLOCK_THR=8, ACQ_MAX_WIN=4.
module tb_cdr_gain_ctrl;

  localparam int unsigned WIN_LEN     = 16;
  localparam int unsigned LOCK_THR    = 2;
  localparam int unsigned UNLOCK_THR  = 8;
  localparam int unsigned ACQ_MAX_WIN = 4;

  logic       BitCLK = 1'b0;
  logic       Reset;
  logic       en;
  logic       early;
  logic       late;
  logic [1:0] gainsel;
  logic       locked;
  logic       gain_upd;
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
  logic       acq_timeout;
`endif

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int upd_seen = 0;

  always #5 BitCLK = ~BitCLK;

  cdr_gain_ctrl #(
    .WIN_LEN     (WIN_LEN),
    .LOCK_THR    (LOCK_THR),
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
    .UNLOCK_THR  (UNLOCK_THR),
    .ACQ_MAX_WIN (ACQ_MAX_WIN)
`else
    .UNLOCK_THR  (UNLOCK_THR)
`endif
  ) dut (
    .BitCLK      (BitCLK),
    .Reset       (Reset),
    .en          (en),
    .early       (early),
    .late        (late),
    .gainsel     (gainsel),
    .locked      (locked),
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
    .gain_upd    (gain_upd),
    .acq_timeout (acq_timeout)
`else
    .gain_upd    (gain_upd)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are then sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge BitCLK);
    #1;
    cyc++;
    if (gain_upd) upd_seen++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_state(input string tag, input logic [1:0] g, input logic l, input logic u);
    check({tag, "_gainsel"}, 32'(gainsel), 32'(g));
    check({tag, "_locked"}, 32'(locked), 32'(l));
    check({tag, "_gain_upd"}, 32'(gain_upd), 32'(u));
  endtask

  initial begin
    Reset = 1'b1;
    en    = 1'b0;
    early = 1'b0;
    late  = 1'b0;
    repeat (3) tick();
    chk_state("reset", 2'd2, 1'b0, 1'b0);
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
    check("reset_timeout", 32'(acq_timeout), 0);
`endif

    // Cycle 1 is ACQ entry; no votes gives quiet windows.
    Reset    = 1'b0;
    en       = 1'b1;
    cyc      = 0;
    upd_seen = 0;
    goto(1);  chk_state("acq_entry", 2'd2, 1'b0, 1'b0);
    goto(16); chk_state("acq_win_end", 2'd2, 1'b0, 1'b0);
    goto(17); chk_state("to_med", 2'd1, 1'b0, 1'b1);
    goto(18); check("med_pulse_end", 32'(gain_upd), 0);
    goto(32); check("med_hold", 32'(gainsel), 1);
    goto(33); chk_state("to_fine", 2'd0, 1'b0, 1'b1);
    goto(48); check("fine_not_locked", 32'(locked), 0);
    goto(49); chk_state("to_locked", 2'd0, 1'b1, 1'b0);
    check("upd_pulses", 32'(upd_seen), 2);

    // 9 late votes in the LOCKED window (cycles 49..57) -> lost.
    late = 1'b1;
    goto(58); late = 1'b0;
    goto(64); chk_state("locked_win_end", 2'd0, 1'b1, 1'b0);
    goto(65); chk_state("lost_to_acq", 2'd2, 1'b0, 1'b1);

    // Constant early in ACQ: net -16 per window, never quiet.
    early = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      goto(65 + 16 * w);
      chk_state($sformatf("acq_early_w%0d", w), 2'd2, 1'b0, 1'b0);
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
      check($sformatf("timeout_w%0d", w), 32'(acq_timeout), (w == 4) ? 1 : 0);
`endif
    end

    // Both votes every cycle cancel out: window starting at 129 reaches LOCKED at 177.
    late = 1'b1;
    goto(145); chk_state("both_to_med", 2'd1, 1'b0, 1'b1);
    goto(161); chk_state("both_to_fine", 2'd0, 1'b0, 1'b1);
    goto(176); check("both_not_locked", 32'(locked), 0);
    goto(177); chk_state("both_to_locked", 2'd0, 1'b1, 1'b0);
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
    check("timeout_sticky", 32'(acq_timeout), 1);
`endif

    // en drop from LOCKED, then drop at counter 7 in MED.
    early = 1'b0;
    late  = 1'b0;
    en    = 1'b0;
    goto(178); chk_state("locked_en_off", 2'd2, 1'b0, 1'b1);
    en = 1'b1;
    goto(195); chk_state("reacq_to_med", 2'd1, 1'b0, 1'b1);
    goto(202); en = 1'b0;
    goto(203); chk_state("med_en_off", 2'd2, 1'b0, 1'b1);
    en = 1'b1;
    goto(219); check("restart_win_hold", 32'(gainsel), 2);
    goto(220); chk_state("restart_to_med", 2'd1, 1'b0, 1'b1);

    // Window end in MED coincides with en low: IDLE, not FINE.
    goto(235); en = 1'b0;
    goto(236); chk_state("win_end_en_off", 2'd2, 1'b0, 1'b1);
    goto(240); chk_state("idle_hold", 2'd2, 1'b0, 1'b0);

    // Reset mid-window with en high discards the partial window.
    en = 1'b1;
    goto(257); check("pre_reset_med", 32'(gainsel), 1);
    goto(260); Reset = 1'b1;
    goto(261); chk_state("mid_reset", 2'd2, 1'b0, 1'b0);
`ifdef CDR_GAIN_CTRL_TIMEOUT_EN
    check("timeout_cleared", 32'(acq_timeout), 0);
`endif
    Reset = 1'b0;
    goto(277); check("post_reset_hold", 32'(gainsel), 2);
    goto(278); chk_state("post_reset_to_med", 2'd1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
